// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to imem
// and hands one instruction plus its PC to decode.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   branch_taken_in     branch redirect request
//   branch_target_in    branch redirect address
//   trap_in             trap redirect request (wins over branch)
//   trap_target_in      trap vector address
//   stall_in            decode cannot accept instr_out this cycle
//   imem_ready_in       imem returns data for the current request
//   imem_rdata_in       instruction word from imem
//   imem_req_out        fetch request
//   imem_addr_out       fetch address (internal fetch PC)
//   pc_out, instr_out   PC and word of the instruction held for decode
//   instr_valid_out     pc_out/instr_out are valid
//   flush_out           one-cycle pulse after every redirect
//   misaligned_out      last redirect target was not word-aligned
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   input  logic        trap_in,
   input  logic [31:0] trap_target_in,
   input  logic        stall_in,
   input  logic        imem_ready_in,
   input  logic [31:0] imem_rdata_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   output logic [31:0] pc_out,
   output logic [31:0] instr_out,
   output logic        instr_valid_out,
   output logic        flush_out,
   output logic        misaligned_out
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic        redirect;
   logic [31:0] target;
   logic        target_mis;
   logic        capture;

   assign redirect   = trap_in | branch_taken_in;
   assign target     = trap_in ? trap_target_in
                               : branch_target_in;
   assign target_mis = |target[1:0];

   // Request only when the output slot is empty or drains this cycle.
   assign imem_req_out  = (state == FETCH) &
                          (!instr_valid_out | !stall_in);
   assign imem_addr_out = fetch_pc;

   // A redirect in the same cycle discards any returned data.
   assign capture = imem_req_out & imem_ready_in & !redirect;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   state_nxt = FETCH;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
      if (redirect) begin
         state_nxt = target_mis ? ERR : FETCH;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         fetch_pc        <= RESET_PC;
         pc_out          <= RESET_PC;
         instr_out       <= NOP;
         instr_valid_out <= 1'b0;
         flush_out       <= 1'b0;
         misaligned_out  <= 1'b0;
      end else begin
         state     <= state_nxt;
         flush_out <= redirect;
         if (redirect) begin
            fetch_pc        <= target;
            instr_valid_out <= 1'b0;
            misaligned_out  <= target_mis;
         end else if (capture) begin
            instr_out       <= imem_rdata_in;
            pc_out          <= fetch_pc;
            instr_valid_out <= 1'b1;
            fetch_pc        <= fetch_pc + 32'd4;
         end else if (instr_valid_out & !stall_in) begin
            instr_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the core: owns the program counter, issues word requests to instruction memory over a single-cycle ready handshake, and presents one fetched instruction plus its PC to decode. It sits directly downstream of the branch unit: the registered `branch_taken` decision and target, plus trap redirects, steer the next fetch address. On every redirect it flushes the younger instruction and checks target alignment.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_in  input  1  reset, synchronous and active-high.
- branch_taken_in  input  1  branch/jump redirect request, from the branch unit.
- branch_target_in  input  32  redirect address for a branch.
- trap_in  input  1  trap redirect request.
- trap_target_in  input  32  trap vector address.
- stall_in  input  1  decode cannot accept `instr_out` this cycle.
- imem_ready_in  input  1  memory returns data for the current request this cycle.
- imem_rdata_in  input  32  instruction word; valid when `imem_ready_in` is high.
- imem_req_out  output  1  fetch request.
- imem_addr_out  output  32  fetch address; equals the internal fetch_pc.
- pc_out  output  32  PC of `instr_out`.
- instr_out  output  32  fetched instruction.
- instr_valid_out  output  1  `instr_out` and `pc_out` are valid.
- flush_out  output  1  one-cycle pulse; decode must drop its current instruction.
- misaligned_out  output  1  last redirect target had target[1:0] != 0.

## Operation
- States: IDLE, FETCH, ERR. Reset enters IDLE.
- Transitions out of IDLE: go to FETCH after exactly one cycle, unless a redirect arrives.
- Redirect condition: `trap_in | branch_taken_in`. It is honoured in every state and overrides stall.
- Target selection: if `trap_in` is high, target = `trap_target_in`; otherwise target = `branch_target_in`. Trap wins when both are high.
- Redirect with an aligned target:
  - fetch_pc <= target; state <= FETCH.
  - `flush_out` <= 1 and `instr_valid_out` <= 0.
  - Any `imem_ready_in` data in the same cycle is discarded.
  - `misaligned_out` <= 0.
- Redirect with a misaligned target:
  - Same flush behaviour as an aligned redirect.
  - fetch_pc <= target; state <= ERR; `misaligned_out` <= 1.
- ERR state:
  - `imem_req_out` = 0 and `misaligned_out` stays 1.
  - Exit only via an aligned redirect or reset.
- FETCH state, request rule: `imem_req_out` = !`instr_valid_out` | !`stall_in`. A request is issued only if the output slot is free or is being consumed this cycle.
- FETCH state, request with `imem_ready_in` and no redirect:
  - `instr_out` <= `imem_rdata_in`; `pc_out` <= fetch_pc; `instr_valid_out` <= 1.
  - fetch_pc <= fetch_pc + 4.
- FETCH state, request without `imem_ready_in`: hold the request and address. Memory wait states are unbounded.
- Output slot drain: if `instr_valid_out` & !`stall_in` and nothing new is captured, `instr_valid_out` <= 0.
- Output slot hold: if `instr_valid_out` & `stall_in`, `instr_out`, `pc_out` and `instr_valid_out` hold unchanged.
- PC arithmetic: fetch_pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. fetch_pc never changes except by increment or redirect.
- Request abandonment: a pending unacknowledged request may be abandoned by a redirect. Memory must accept an address change while ready is low.

## Timing
- Reset values (on the first edge with `rst_in` high):
  - fetch_pc = RESET_PC, so `imem_addr_out` = RESET_PC and `pc_out` = RESET_PC.
  - `instr_out` = 32'h0000_0013 (NOP).
  - `imem_req_out`, `instr_valid_out`, `flush_out` and `misaligned_out` = 0.
- Reset asserted mid-operation: all state returns to reset values on that edge. Same-cycle ready data is ignored.
- First request: `imem_req_out` goes high in the second cycle after `rst_in` falls (IDLE lasts one cycle).
- Fetch latency: `imem_ready_in` in cycle k gives `instr_valid_out` = 1 in cycle k+1.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Redirect latency: a redirect sampled at edge N gives, in cycle N+1:
  - `flush_out` = 1 for that single cycle;
  - `imem_addr_out` = target;
  - `instr_valid_out` = 0.
- Back-to-back redirects: each one pulses `flush_out`; the last one wins.

## Test plan
- Reset, then `imem_ready_in` held at 1 and no stall -> requests go out at addresses 0, 4, 8 on consecutive cycles. `instr_valid_out` rises one cycle after each ready, with `pc_out` = 0, 4, 8.
- Stall for 3 cycles while `instr_out` = 32'h0050_0093 at `pc_out` = 8 -> outputs hold, `imem_req_out` = 0 during the stall, and fetch resumes at 12 after the stall clears.
- `branch_taken_in` = 1, target 32'h0000_0100, with ready in the same cycle -> ready data discarded, `flush_out` pulses once, the next request is at 32'h100 and the next valid `pc_out` = 32'h100.
- `trap_in` and `branch_taken_in` in the same cycle (trap 32'h0000_0200, branch 32'h0000_0300) -> fetch resumes at 32'h200.
- Branch to 32'h0000_0102 -> `misaligned_out` = 1, no requests issued. A later aligned branch to 32'h0000_0400 clears `misaligned_out` and fetches from 32'h400.
- Redirect to 32'hFFFF_FFFC with ready = 1 -> the following request address is 32'h0000_0000 (wrap-around). Asserting `rst_in` mid-wait returns `imem_addr_out` to RESET_PC on the next edge.
